pc_stack: RTL and testbench

- Parametrised next-generation program counter for the CPU fetch path.
- Keeps the original load/inc/hold counter and adds a clock-enable (stall), call/return with an internal return-address stack (RAS), and sticky overflow/underflow error flags.
- Sits between the control unit and the instruction ROM address bus.

---
 rtl/pc_stack.sv | 153 +++++++++++++++
 tb/tb_pc_stack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
//   Program counter for the CPU fetch path. It supports load, increment and
//   hold, a clock enable (stall), and call/return through an internal
//   return-address stack (RAS). It also has sticky overflow and underflow
//   flags.
//
//   When en==1, exactly one action is taken per edge. The priority order is:
//     load > [rel] > ret > call > inc > hold
//   Lower-priority requests are dropped with no side effects.
//
//   Optional build macro: PC_REL_BRANCH_EN
//     Adds the `rel` input. rel performs out <= out + in, where `in` is
//     treated as two's complement. Its priority sits between load and ret.
//
// Parameters
//   WIDTH : PC / target / stack entry width
//   DEPTH : RAS entries (power of 2, >= 2)
//   CW    : width of `depth` (derived, do not override)
//
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous reset, active low
//   en      : clock enable (0 = stall, everything holds)
//   inc     : increment request
//   load    : absolute jump to `in`
//   call    : push out+1, jump to `in`
//   ret     : pop return address into out
//   clr_err : synchronous clear of ovf/unf (only while en==1)
//   rel     : relative branch (PC_REL_BRANCH_EN builds only)
//   in      : jump / call / branch target
//   out     : current PC (registered)
//   depth   : number of valid RAS entries, 0..DEPTH
//   ovf     : sticky, a call was made with the stack full
//   unf     : sticky, a return was made with the stack empty
// -----------------------------------------------------------------------------
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             clr_err,
`ifdef PC_REL_BRANCH_EN
  input  logic             rel,
`endif
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    depth,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [CW-1:0]    r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic             w_rel;
  logic [WIDTH-1:0] w_pc_inc;
  logic [CW-1:0]    w_depth_m1;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [CW-1:0]    w_depth_nxt;
  logic             w_push;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic [CW-AW-1:0] w_unused_msb;

`ifdef PC_REL_BRANCH_EN
  assign w_rel = rel;
`else
  assign w_rel = 1'b0;
`endif

  assign w_pc_inc   = r_pc + WIDTH'(1);
  assign w_depth_m1 = r_depth - CW'(1);
  assign w_full     = (r_depth == CW'(DEPTH));
  assign w_empty    = (r_depth == '0);

  // The pop index only needs the low AW bits. When depth>0, depth-1 is below
  // DEPTH, so the upper bits of w_depth_m1 are always zero.
  assign w_unused_msb = w_depth_m1[CW-1:AW];

  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    if (load) begin
      w_pc_nxt = in;
    end else if (w_rel) begin
      w_pc_nxt = r_pc + in;
    end else if (ret) begin
      if (!w_empty) begin
        w_pc_nxt    = r_stack[w_depth_m1[AW-1:0]];
        w_depth_nxt = w_depth_m1;
      end else begin
        w_set_unf = 1'b1;
      end
    end else if (call) begin
      // A call always jumps. Only the push is suppressed when the stack is full.
      w_pc_nxt = in;
      if (!w_full) begin
        w_push      = 1'b1;
        w_depth_nxt = r_depth + CW'(1);
      end else begin
        w_set_ovf = 1'b1;
      end
    end else if (inc) begin
      w_pc_nxt = w_pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (en) begin
      r_pc    <= w_pc_nxt;
      r_depth <= w_depth_nxt;
      // If clr_err and a new error occur on the same edge, the set wins.
      r_ovf   <= (r_ovf & ~clr_err) | w_set_ovf;
      r_unf   <= (r_unf & ~clr_err) | w_set_unf;
    end
  end

  // The stack contents are don't-care after reset, so they are left unreset.
  always_ff @(posedge clk) begin
    if (en && w_push) begin
      r_stack[r_depth[AW-1:0]] <= w_pc_inc;
    end
  end

  assign out   = r_pc;
  assign depth = r_depth;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             reset;
  logic             en, inc, load, call, ret, clr_err, rel;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    depth;
  logic             ovf, unf;

  int errors = 0;
  int checks = 0;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .load(load),
    .call(call), .ret(ret), .clr_err(clr_err),
`ifdef PC_REL_BRANCH_EN
    .rel(rel),
`endif
    .in(in), .out(out), .depth(depth), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: a plain queue is the return-address stack.
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_q[$];
  logic             m_ovf, m_unf;

  task automatic model_reset();
    m_out = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic i, input logic l,
                            input logic c, input logic r, input logic cl,
                            input logic rl, input logic [WIDTH-1:0] d);
    logic rel_active;
`ifdef PC_REL_BRANCH_EN
    rel_active = rl;
`else
    rel_active = 1'b0;
`endif
    if (e) begin
      if (cl) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (l) m_out = d;
      else if (rel_active) m_out = WIDTH'(m_out + d);
      else if (r) begin
        if (m_q.size() > 0) m_out = m_q.pop_back();
        else m_unf = 1'b1;
      end else if (c) begin
        if (m_q.size() < DEPTH) m_q.push_back(WIDTH'(m_out + 1));
        else m_ovf = 1'b1;
        m_out = d;
      end else if (i) m_out = WIDTH'(m_out + 1);
    end
  endtask

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int unsigned e_out,
                           input int unsigned e_depth, input int unsigned e_ovf,
                           input int unsigned e_unf);
    check({name, ".out"}, int'(out), e_out);
    check({name, ".depth"}, int'(depth), e_depth);
    check({name, ".ovf"}, int'(ovf), e_ovf);
    check({name, ".unf"}, int'(unf), e_unf);
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic apply(input logic e, input logic i, input logic l, input logic c,
                       input logic r, input logic cl, input logic rl,
                       input logic [WIDTH-1:0] d);
    en = e; inc = i; load = l; call = c; ret = r; clr_err = cl; rel = rl; in = d;
    @(posedge clk);
    model_step(e, i, l, c, r, cl, rl, d);
    #1;
    en = 1'b1; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    clr_err = 1'b0; rel = 1'b0;
  endtask

  typedef struct {
    logic             e, i, l, c, r, cl;
    logic [WIDTH-1:0] d;
    int unsigned      x_out, x_depth, x_ovf, x_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic i, input logic l, input logic c,
                     input logic r, input logic cl, input logic [WIDTH-1:0] d,
                     input int unsigned xo, input int unsigned xd,
                     input int unsigned xv, input int unsigned xu);
    vec_t v;
    v.e = e; v.i = i; v.l = l; v.c = c; v.r = r; v.cl = cl; v.d = d;
    v.x_out = xo; v.x_depth = xd; v.x_ovf = xv; v.x_unf = xu;
    vecs.push_back(v);
  endtask

  initial begin
    // Table, applied from out=0, depth=0.
    //   en inc ld cal ret clr  in      out  dep ovf unf
    add(1, 0, 1, 0, 0, 0, 16'd25,    25,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'd0,     25,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'd0,     25,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'd0,     25,    0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 16'd0,     25,    0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 16'd0,     26,    0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd65535, 65535, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 16'd0,     0,     0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd100,   100,   0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 16'd527,   527,   1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 16'd40,    40,    2, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,     528,   1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,     101,   0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 16'd1000,  1000,  1, 0, 0);
    add(1, 0, 0, 1, 0, 0, 16'd2000,  2000,  2, 0, 0);
    add(1, 1, 1, 1, 1, 0, 16'd300,   300,   2, 0, 0);
    add(1, 0, 0, 1, 1, 0, 16'd5,     1001,  1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,     102,   0, 0, 0);
    // Push 0xFFFF+1, which wraps to 0, then pop it back.
    add(1, 0, 1, 0, 0, 0, 16'hFFFF,  65535, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 16'd7,     7,     1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 16'd0,     0,     0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'd102,   102,   0, 0, 0);

    en = 1'b0; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
    clr_err = 1'b0; rel = 1'b0; in = '0;
    reset = 1'b0;
    model_reset();
    #3;
    check_all("reset", 0, 0, 0, 0);

    // Count 5 edges, then apply an asynchronous reset between edges.
    reset = 1'b1; en = 1'b1; inc = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("count5.out", int'(out), 5);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset.out", int'(out), 0);
    check("async_reset.depth", int'(depth), 0);
    @(negedge clk);
    inc = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("release_hold.out", int'(out), 0);

    foreach (vecs[k]) begin
      apply(vecs[k].e, vecs[k].i, vecs[k].l, vecs[k].c, vecs[k].r, vecs[k].cl,
            1'b0, vecs[k].d);
      check_all($sformatf("vec%0d", k), vecs[k].x_out, vecs[k].x_depth,
                vecs[k].x_ovf, vecs[k].x_unf);
    end

    // Overflow: 9 calls starting from out=102, depth=0.
    for (int k = 1; k <= 9; k++) apply(1, 0, 0, 1, 0, 0, 1'b0, WIDTH'(10 * k));
    check_all("ovf9", 90, 8, 1, 0);
    // Unwind in LIFO order: 71, 61, ..., 11, then 103.
    for (int j = 8; j >= 1; j--) begin
      apply(1, 0, 0, 0, 1, 0, 1'b0, '0);
      check($sformatf("unwind%0d.out", j), int'(out),
            (j == 1) ? 103 : 10 * (j - 1) + 1);
      check($sformatf("unwind%0d.depth", j), int'(depth), j - 1);
    end
    apply(1, 0, 0, 0, 1, 0, 1'b0, '0);
    check_all("underflow", 103, 0, 1, 1);
    // clr_err is ignored while stalled.
    apply(0, 0, 0, 0, 0, 1, 1'b0, '0);
    check_all("clr_stalled", 103, 0, 1, 1);
    apply(1, 0, 0, 0, 0, 1, 1'b0, '0);
    check_all("clr_err", 103, 0, 0, 0);
    // When clearing and a new error occur on the same edge, the set wins.
    apply(1, 0, 0, 0, 1, 1, 1'b0, '0);
    check_all("clr_vs_set", 103, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 1, 1'b0, '0);

`ifdef PC_REL_BRANCH_EN
    apply(1, 0, 1, 0, 0, 0, 1'b0, 16'd200);
    apply(1, 0, 0, 0, 0, 0, 1'b1, 16'hFFF0);
    check("rel_neg.out", int'(out), 184);
    apply(1, 0, 1, 0, 0, 0, 1'b1, 16'd7);
    check("rel_vs_load.out", int'(out), 7);
    apply(1, 0, 0, 1, 0, 0, 1'b0, 16'd50);
    apply(1, 0, 0, 0, 1, 0, 1'b1, 16'd3);
    check_all("rel_vs_ret", 53, 1, 0, 0);
`endif

    // Randomized traffic checked against the queue model.
    for (int n = 0; n < 400; n++) begin
      logic re, ri, rlo, rc, rr, rcl, rrl;
      logic [WIDTH-1:0] rd;
      re  = ($urandom_range(9) != 0);
      ri  = ($urandom_range(1) == 1);
      rlo = ($urandom_range(9) == 0);
      rc  = ($urandom_range(3) == 0);
      rr  = ($urandom_range(3) == 0);
      rcl = ($urandom_range(11) == 0);
      rrl = ($urandom_range(9) == 0);
      rd  = WIDTH'($urandom);
      if ($urandom_range(7) == 0) rd = 16'hFFFF;
      apply(re, ri, rlo, rc, rr, rcl, rrl, rd);
      check_all($sformatf("rand%0d", n), int'(m_out), m_q.size(),
                int'(m_ovf), int'(m_unf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
